io_led_switch_port: RTL and testbench
=====================================

# io_led_switch_port

Peripheral-side responder for the CPU memory-mapped IO bridge. It receives the bridge's LED and switch chip selects plus write data, holds the 24 board LEDs in registers, and synchronizes and debounces the 16 slide switches into the value the bridge returns on an IO read. It also turns the confirm push-button into a sticky `check` flag that the bridge polls, cleared by the read strobe. It sits between the bridge and the board pins.

## Interface
- `DB_CYCLES`, default 1000000: stable-cycle count required to accept a new pad value (10 ms at 100 MHz); must be ≥ 2.
- `clk` in 1: single system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `led_low_cs` in 1: one-cycle write strobe for LEDs [15:0].
- `led_high_cs` in 1: one-cycle write strobe for LEDs [23:16].
- `switch_cs` in 1: switch read select; informational only, read data is always valid.
- `check_rd` in 1: one-cycle strobe, bridge read of the check address; clears the flag.
- `wdata` in 16: low half of bridge write data.
- `sw_pad` in 16: raw, asynchronous switch pins.
- `btn_pad` in 1: raw, asynchronous confirm button, active-high.
- `led` out 24: registered LED drive.
- `switch_rdata` out 16: registered debounced switch value, which becomes the bridge's `bdata`.
- `check` out 1: registered sticky button-press flag.

## Operation
- LED write, `led_low_cs` = 1: `led[15:0]` <= `wdata`.
- LED write, `led_high_cs` = 1: `led[23:16]` <= `wdata[7:0]`.
- Both strobes high in the same cycle: both halves update.
- No strobe: LEDs hold their value.
- Synchronizer: two flops per pad bit, 17 bits total (16 switches + button).
- Debounce, per group (switch vector, button):
  - `cand` register and counter `cnt`, width `$clog2(DB_CYCLES)`.
  - When the synchronized value ≠ `cand`: `cand` <= synchronized value, `cnt` <= 0.
  - Otherwise, if `cnt` = DB_CYCLES−1: `stable` <= `cand`; `cnt` holds.
  - Otherwise `cnt` increments.
  - The switch group is one shared vector: any single bit toggle restarts the whole vector's count.
- `switch_rdata` = switch `stable` register.
- `btn_stable` is the button group's `stable` register. Its rising edge, `btn_stable` = 1 while the previous-cycle copy = 0, sets `check` on the following edge.
- Flag clear: `check_rd` = 1 clears `check` on the next edge.
  - The bridge sees `check` = 1 during the `check_rd` cycle.
  - Set and clear in the same cycle: set wins, so a press is never lost.
- Pad glitches shorter than DB_CYCLES cycles never reach `stable`.

## Timing
- Reset (async assert, sync release): `led` = 0, `switch_rdata` = 0, `check` = 0; synchronizers, `cand`, `stable`, `cnt` and the edge flop all 0.
- Reset mid-debounce discards the count. Pads already high at reset appear after a full debounce interval.
- LED write latency: 1 edge, with strobe and data sampled together.
- Pad-to-output latency, pad constant from before edge k:
  - Synchronized value valid after edge k+1.
  - `stable` and `switch_rdata` update at edge k+1+DB_CYCLES.
  - `check` rises one edge after `btn_stable`.
- Outputs never change combinationally from inputs.

## Configuration
- `IO_DEBOUNCE_EN` defined: debounce as above.
- `IO_DEBOUNCE_EN` undefined:
  - `stable` = synchronized value, registered, so `switch_rdata` updates at edge k+2.
  - No counters.
  - `DB_CYCLES` is ignored.
  - The button edge detect runs on the synchronized value.

## Structure
- Shared IO package holds:
  - LED and switch width constants (16, 8, 16).
  - The IO address constants the bridge decodes (0x60, 0x62, 0x70, 0x20).
  - The default `DB_CYCLES`.
- One sub-module, `io_debounce`: parameters WIDTH and DB_CYCLES; two-flop synchronizer + candidate/counter/stable. Instantiated twice: WIDTH 16 for switches, WIDTH 1 for the button.
- Edge detect, sticky flag and LED registers live in the top module.

## Test plan
Run with DB_CYCLES = 4 and `IO_DEBOUNCE_EN` defined unless noted.
- Reset, then `led_low_cs` with `wdata` 0xA5C3, then `led_high_cs` with `wdata` 0x12FF: `led` = 0x00A5C3 after the first edge, 0xFFA5C3 after the second. Both strobes with 0x0F0F gives 0x0F0F0F.
- `sw_pad` steps 0x0000→0x8001 before edge k: `switch_rdata` stays 0x0000 through edge k+4 and equals 0x8001 after edge k+5.
- `sw_pad` glitch to 0xFFFF for 3 cycles, then back to 0: `switch_rdata` stays 0x0000 throughout.
- `btn_pad` held high 10 cycles: `check` rises exactly one edge after `btn_stable`. `check_rd` pulse clears it next edge. A `check_rd` in the same cycle as a new set leaves `check` = 1.
- `rst_n` asserted mid-count with `sw_pad` = 0x00FF and LEDs set: all outputs go to 0 immediately. After release, `switch_rdata` reaches 0x00FF only after a full interval.
- `IO_DEBOUNCE_EN` undefined: `sw_pad` 0x1234 before edge k appears on `switch_rdata` after edge k+2. A 1-cycle button pulse sets `check`.

Source files
------------

// File: rtl/io_led_switch_port_pkg.sv
// Shared IO constants for the LED/switch responder and the bridge decode.
package io_led_switch_port_pkg;

  // LED and switch widths
  localparam int unsigned LedLowW  = 16;
  localparam int unsigned LedHighW = 8;
  localparam int unsigned LedW     = LedLowW + LedHighW;
  localparam int unsigned SwW      = 16;

  // IO addresses decoded by the bridge
  localparam logic [7:0] IoAddrLedLow  = 8'h60;
  localparam logic [7:0] IoAddrLedHigh = 8'h62;
  localparam logic [7:0] IoAddrSwitch  = 8'h70;
  localparam logic [7:0] IoAddrCheck   = 8'h20;

  // 10 ms at 100 MHz
  localparam int unsigned DbCyclesDefault = 1000000;

endpackage

// File: rtl/io_led_switch_port_if.sv
// Bridge-side bus between the IO bridge (master) and the LED/switch port (slave).
interface io_led_switch_port_if;
  import io_led_switch_port_pkg::*;

  logic               led_low_cs;
  logic               led_high_cs;
  logic               switch_cs;
  logic               check_rd;
  logic [LedLowW-1:0] wdata;
  logic [SwW-1:0]     switch_rdata;
  logic               check;

  modport master (
    output led_low_cs, led_high_cs, switch_cs, check_rd, wdata,
    input  switch_rdata, check
  );

  modport slave (
    input  led_low_cs, led_high_cs, switch_cs, check_rd, wdata,
    output switch_rdata, check
  );

endinterface

// File: rtl/io_led_switch_port_debounce.sv
// io_debounce: two-flop synchronizer followed by a shared-vector debouncer.
// Debounce is only built when IO_DEBOUNCE_EN is defined; otherwise the
// synchronized value is simply registered.
module io_debounce #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_pad,
  output logic [WIDTH-1:0] o_stable
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;

  // Two-flop synchronizer for the asynchronous pads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CntW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] r_cand;
  logic [CntW-1:0]  r_cnt;

  // cand tracks the value entering the second sync stage, so it always equals
  // r_sync2 after an edge; this lands the stable update DB_CYCLES edges after
  // the synchronized value becomes valid.
  logic w_unused_sync2;
  assign w_unused_sync2 = ^r_sync2;

  // Candidate / counter / stable: any bit change restarts the whole vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else if (r_sync1 != r_cand) begin
      r_cand <= r_sync1;
      r_cnt  <= '0;
    end else if (r_cnt == CntMax) begin
      r_stable <= r_cand;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end
`else
  localparam int unsigned UnusedDbCycles = DB_CYCLES;

  // No debounce: register the synchronized value directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
    end else begin
      r_stable <= r_sync2;
    end
  end
`endif

  assign o_stable = r_stable;

endmodule

// File: rtl/io_led_switch_port.sv
// io_led_switch_port: LED registers, debounced switch read value and sticky
// confirm-button flag behind the IO bridge.
// Build option: define IO_DEBOUNCE_EN to enable pad debouncing.
module io_led_switch_port
  import io_led_switch_port_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_led_switch_port_if.slave   bus,
  input  logic [SwW-1:0]        sw_pad,
  input  logic                  btn_pad,
  output logic [LedW-1:0]       led
);

  logic [LedW-1:0] r_led;
  logic            r_check;
  logic            r_btn_prev;
  logic [SwW-1:0]  w_sw_stable;
  logic            w_btn_stable;
  logic            w_btn_rise;

  // Read data is always valid; the select is not needed here
  logic w_unused_switch_cs;
  assign w_unused_switch_cs = bus.switch_cs;

  io_debounce #(
    .WIDTH     (SwW),
    .DB_CYCLES (DB_CYCLES)
  ) u_sw_db (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_pad    (sw_pad),
    .o_stable (w_sw_stable)
  );

  io_debounce #(
    .WIDTH     (1),
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_db (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_pad    (btn_pad),
    .o_stable (w_btn_stable)
  );

  // LED halves written independently by their strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      if (bus.led_low_cs) begin
        r_led[LedLowW-1:0] <= bus.wdata;
      end
      if (bus.led_high_cs) begin
        r_led[LedW-1:LedLowW] <= bus.wdata[LedHighW-1:0];
      end
    end
  end

  assign w_btn_rise = w_btn_stable & ~r_btn_prev;

  // Sticky check flag: a press (set) beats a simultaneous read (clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_prev <= 1'b0;
      r_check    <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_stable;
      if (w_btn_rise) begin
        r_check <= 1'b1;
      end else if (bus.check_rd) begin
        r_check <= 1'b0;
      end
    end
  end

  assign led              = r_led;
  assign bus.switch_rdata = w_sw_stable;
  assign bus.check        = r_check;

endmodule

// File: tb/tb_io_led_switch_port.sv
// Directed self-checking bench for io_led_switch_port (DB_CYCLES = 4).
module tb_io_led_switch_port;

`ifdef IO_DEBOUNCE_EN
  localparam int SwLat     = 5;  // pad-before-edge-k to switch_rdata, edges after k
  localparam int ChkLat    = 6;  // pad-before-edge-k to check set
  localparam bit PulseSets = 1'b0;
`else
  localparam int SwLat     = 2;
  localparam int ChkLat    = 3;
  localparam bit PulseSets = 1'b1;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] sw_pad;
  logic        btn_pad;
  logic [23:0] led;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  io_led_switch_port_if bus ();

  io_led_switch_port #(
    .DB_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sw_pad  (sw_pad),
    .btn_pad (btn_pad),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pad already changed before the next edge k; watch k .. k+SwLat
  task automatic expect_sw(input string tag, input logic [15:0] old_v,
                           input logic [15:0] new_v);
    for (int e = 0; e <= SwLat; e++) begin
      step();
      chk(tag, {16'h0, bus.switch_rdata}, {16'h0, (e >= SwLat) ? new_v : old_v});
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    sw_pad          = '0;
    btn_pad         = 1'b0;
    bus.led_low_cs  = 1'b0;
    bus.led_high_cs = 1'b0;
    bus.switch_cs   = 1'b0;
    bus.check_rd    = 1'b0;
    bus.wdata       = '0;

    // Reset state
    step();
    step();
    chk("rst_led", {8'h0, led}, 32'h0);
    chk("rst_sw", {16'h0, bus.switch_rdata}, 32'h0);
    chk("rst_check", {31'h0, bus.check}, 32'h0);
    rst_n = 1'b1;

    // LED writes
    bus.led_low_cs = 1'b1;
    bus.wdata      = 16'hA5C3;
    step();
    bus.led_low_cs = 1'b0;
    chk("led_low", {8'h0, led}, 32'h00A5C3);
    bus.led_high_cs = 1'b1;
    bus.wdata       = 16'h12FF;
    step();
    bus.led_high_cs = 1'b0;
    chk("led_high", {8'h0, led}, 32'hFFA5C3);
    bus.led_low_cs  = 1'b1;
    bus.led_high_cs = 1'b1;
    bus.wdata       = 16'h0F0F;
    step();
    bus.led_low_cs  = 1'b0;
    bus.led_high_cs = 1'b0;
    chk("led_both", {8'h0, led}, 32'h0F0F0F);
    bus.wdata = 16'hFFFF;
    step();
    chk("led_hold", {8'h0, led}, 32'h0F0F0F);

    // Switch step 0x0000 -> 0x8001
    bus.switch_cs = 1'b1;
    sw_pad = 16'h8001;
    expect_sw("sw_step", 16'h0000, 16'h8001);
    sw_pad = 16'h0000;
    expect_sw("sw_back", 16'h8001, 16'h0000);

    // Three-cycle glitch
    sw_pad = 16'hFFFF;
    step();
    step();
    step();
    sw_pad = 16'h0000;
`ifdef IO_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) begin
      chk("sw_glitch", {16'h0, bus.switch_rdata}, 32'h0);
      step();
    end
`else
    chk("sw_glitch_pass", {16'h0, bus.switch_rdata}, 32'hFFFF);
    for (int i = 0; i < 6; i++) step();
    chk("sw_glitch_end", {16'h0, bus.switch_rdata}, 32'h0);
`endif

    // Button held 10 cycles
    btn_pad = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      chk("btn_hold", {31'h0, bus.check}, {31'h0, (e >= ChkLat)});
    end
    btn_pad = 1'b0;
    step();
    chk("btn_sticky", {31'h0, bus.check}, 32'h1);
    bus.check_rd = 1'b1;
    chk("btn_rd_cycle", {31'h0, bus.check}, 32'h1);
    step();
    bus.check_rd = 1'b0;
    chk("btn_cleared", {31'h0, bus.check}, 32'h0);
    for (int i = 0; i < 8; i++) step();
    chk("btn_release", {31'h0, bus.check}, 32'h0);

    // Single-cycle button pulse
    btn_pad = 1'b1;
    step();
    btn_pad = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("btn_pulse", {31'h0, bus.check}, {31'h0, PulseSets});
    bus.check_rd = 1'b1;
    step();
    bus.check_rd = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("btn_pulse_clr", {31'h0, bus.check}, 32'h0);

    // Set and clear in the same cycle: set wins
    btn_pad = 1'b1;
    for (int e = 0; e < ChkLat; e++) begin
      step();
      chk("setclr_pre", {31'h0, bus.check}, 32'h0);
    end
    bus.check_rd = 1'b1;
    step();
    bus.check_rd = 1'b0;
    btn_pad = 1'b0;
    chk("setclr_win", {31'h0, bus.check}, 32'h1);

    // Reset mid-count
    sw_pad = 16'h0F0F;
    for (int i = 0; i < 8; i++) step();
    chk("pre_rst_sw", {16'h0, bus.switch_rdata}, 32'h0F0F);
    sw_pad = 16'h00FF;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", {8'h0, led}, 32'h0);
    chk("mid_rst_sw", {16'h0, bus.switch_rdata}, 32'h0);
    chk("mid_rst_check", {31'h0, bus.check}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    expect_sw("post_rst_sw", 16'h0000, 16'h00FF);
    chk("post_rst_led", {8'h0, led}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
